// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor: latches two WIDTH-bit operands and streams them LSB-first
// through a single-bit subtract cell, returning diff = a - b - borrow_in and a final borrow.

// Half subtractor: d = x - y, borrow when x < y.
module serial_sub_half (
    input  logic x,
    input  logic y,
    output logic d_c,
    output logic b_c
);
    assign d_c = x ^ y;
    assign b_c = ~x & y;
endmodule

// Full single-bit subtract cell built from two half subtractors.
module serial_sub_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d_c,
    output logic bout_c
);
    logic d1;
    logic b1;
    logic b2;

    serial_sub_half u_hs0 (
        .x   (a),
        .y   (b),
        .d_c (d1),
        .b_c (b1)
    );

    serial_sub_half u_hs1 (
        .x   (d1),
        .y   (bin),
        .d_c (d_c),
        .b_c (b2)
    );

    assign bout_c = b1 | b2;
endmodule

module serial_sub_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             borrow_in,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);
    localparam int unsigned CNT_W = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic             load_c;
    logic             shift_c;
    logic             last_c;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             br;
    logic [CNT_W-1:0] cnt;

    logic             cell_d_c;
    logic             cell_b_c;

    serial_sub_cell u_cell (
        .a      (a_sr[0]),
        .b      (b_sr[0]),
        .bin    (br),
        .d_c    (cell_d_c),
        .bout_c (cell_b_c)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and datapath strobes
    always_comb begin
        state_next = state;
        load_c     = 1'b0;
        shift_c    = 1'b0;
        last_c     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    load_c     = 1'b1;
                    state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                shift_c = 1'b1;
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    last_c     = 1'b1;
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                // Back-to-back: a start in DONE reloads without passing through IDLE.
                if (start) begin
                    load_c     = 1'b1;
                    state_next = S_SHIFT;
                end else begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Operand shift registers, borrow flop and bit counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            br     <= 1'b0;
            cnt    <= '0;
        end else if (load_c) begin
            a_sr <= a;
            b_sr <= b;
            br   <= borrow_in;
            cnt  <= '0;
        end else if (shift_c) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            res_sr <= {cell_d_c, res_sr[WIDTH-1:1]};
            br     <= cell_b_c;
            if (!last_c) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Result registers update only on the final shift edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff       <= '0;
            borrow_out <= 1'b0;
        end else if (last_c) begin
            diff       <= {cell_d_c, res_sr[WIDTH-1:1]};
            borrow_out <= cell_b_c;
        end
    end

    // Status flags registered from the next state so they align with the state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_next == S_SHIFT);
            done <= (state_next == S_DONE);
        end
    end
endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed and randomized checks of serial_sub_ctrl (WIDTH=8) against hand-computed
// and modelled results.
module tb_serial_sub_ctrl;
    logic       clk;
    logic       rst_n;
    logic       start;
    logic       borrow_in;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       borrow_out;

    int unsigned n_tests;
    int unsigned n_fail;
    logic [7:0]  prev_diff;
    int unsigned overlap;

    serial_sub_ctrl #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .borrow_in  (borrow_in),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One isolated operation: latency, busy width, held result, final result, done pulse width.
    task automatic run_op(input logic [7:0] oa, input logic [7:0] ob, input logic obin,
                          input logic [7:0] ediff, input logic ebout);
        int unsigned cycles;
        int unsigned busy_cnt;
        @(negedge clk);
        start = 1'b1; a = oa; b = ob; borrow_in = obin;
        @(negedge clk);
        start = 1'b0; a = ~oa; b = ~ob; borrow_in = ~obin;
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("diff_held", 32'(diff), 32'(prev_diff));
        cycles = 0;
        busy_cnt = 1;
        while (!done && cycles < 20) begin
            @(negedge clk);
            cycles++;
            if (busy) busy_cnt++;
            if (busy && done) overlap++;
        end
        chk("latency", cycles, 32'd8);
        chk("busy_cycles", busy_cnt - (busy ? 32'd1 : 32'd0), 32'd8);
        chk("diff", 32'(diff), 32'(ediff));
        chk("borrow_out", 32'(borrow_out), 32'(ebout));
        @(negedge clk);
        chk("done_pulse", 32'(done), 32'd0);
        prev_diff = ediff;
    endtask

    initial begin
        logic [7:0] ops_a [4];
        logic [7:0] ops_b [4];
        logic       ops_c [4];
        logic [7:0] exp_d [4];
        logic       exp_b [4];
        int unsigned cycles;
        int unsigned dones;
        logic       seen;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rc;
        logic [8:0] m;

        n_tests = 0; n_fail = 0; overlap = 0; prev_diff = 8'h00;
        rst_n = 1'b0; start = 1'b0; borrow_in = 1'b0; a = 8'h00; b = 8'h00;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_bout", 32'(borrow_out), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op(8'h35, 8'h12, 1'b0, 8'h23, 1'b0);
        run_op(8'h12, 8'h35, 1'b0, 8'hDD, 1'b1);
        run_op(8'h80, 8'h7F, 1'b1, 8'h00, 1'b0);
        run_op(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1);

        // Back-to-back with start held high; operands scrambled while shifting
        ops_a = '{8'h35, 8'h12, 8'hFF, 8'h01};
        ops_b = '{8'h12, 8'h35, 8'h01, 8'hFF};
        ops_c = '{1'b0, 1'b0, 1'b1, 1'b0};
        exp_d = '{8'h23, 8'hDD, 8'hFD, 8'h02};
        exp_b = '{1'b0, 1'b1, 1'b0, 1'b1};
        @(negedge clk);
        start = 1'b1; a = ops_a[0]; b = ops_b[0]; borrow_in = ops_c[0];
        for (int i = 0; i < 4; i++) begin
            cycles = 0;
            seen = 1'b0;
            while (!seen && cycles < 30) begin
                @(negedge clk);
                cycles++;
                if (busy && done) overlap++;
                if (done) begin
                    seen = 1'b1;
                end else begin
                    a = 8'($urandom); b = 8'($urandom); borrow_in = 1'($urandom);
                end
            end
            chk("b2b_period", cycles, 32'd9);
            chk("b2b_diff", 32'(diff), 32'(exp_d[i]));
            chk("b2b_bout", 32'(borrow_out), 32'(exp_b[i]));
            if (i < 3) begin
                a = ops_a[i+1]; b = ops_b[i+1]; borrow_in = ops_c[i+1];
            end else begin
                start = 1'b0;
            end
        end
        @(negedge clk);
        prev_diff = 8'h02;

        // Reset in the middle of an operation
        @(negedge clk);
        start = 1'b1; a = 8'h35; b = 8'h12; borrow_in = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_diff", 32'(diff), 32'd0);
        chk("midrst_bout", 32'(borrow_out), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (15) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk("midrst_no_done", dones, 32'd0);
        prev_diff = 8'h00;
        run_op(8'hA7, 8'h3C, 1'b1, 8'h6A, 1'b0);

        // Randomized operations against an arithmetic model
        for (int k = 0; k < 1000; k++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            m = {1'b0, ra} - {1'b0, rb} - 9'(rc);
            run_op(ra, rb, rc, m[7:0], m[8]);
        end

        chk("busy_done_overlap", overlap, 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
